// File: rtl/pll_ctrl_pkg.sv
// Shared types and helpers for the PLL supervisor: state encoding, field widths,
// and the multiplier mapping applied before fbdiv reaches pll_core.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    ACQUIRE,
    LOCKED,
    ERROR
  } pll_ctrl_state_e;

  localparam int FBDIV_W = 8;
  localparam int RETRY_W = 2;
  localparam logic [RETRY_W-1:0] RETRY_SAT = '1;

  // pll_core cannot divide by zero, so a zero request is run as x1.
  function automatic logic [FBDIV_W-1:0] fbdiv_map(input logic [FBDIV_W-1:0] fbdiv);
    return (fbdiv == '0) ? FBDIV_W'(1) : fbdiv;
  endfunction

endpackage

// File: rtl/pll_ctrl_if.sv
// System-control and pll_core facing signals of the PLL supervisor.
// master = the system/PLL side driving requests and lock; slave = pll_ctrl.
interface pll_ctrl_if;
  import pll_ctrl_pkg::*;

  logic               req_en;
  logic [FBDIV_W-1:0] req_fbdiv;
  logic               pll_lock;
  logic               pll_en;
  logic [FBDIV_W-1:0] pll_fbdiv;
  logic               ready;
  logic               busy;
  logic               err_timeout;
  logic               lock_lost;
  logic [RETRY_W-1:0] retry_cnt;

  modport master (
    output req_en, req_fbdiv, pll_lock,
    input  pll_en, pll_fbdiv, ready, busy, err_timeout, lock_lost, retry_cnt
  );

  modport slave (
    input  req_en, req_fbdiv, pll_lock,
    output pll_en, pll_fbdiv, ready, busy, err_timeout, lock_lost, retry_cnt
  );

endinterface

// File: rtl/pll_ctrl_timer.sv
// Loadable down-counter shared by the settle and lock-timeout windows.
// Stops at zero instead of wrapping; expire flags the last cycle of a window.
module pll_ctrl_timer #(
  parameter int TIMER_W = 11
) (
  input  logic               rclk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [TIMER_W-1:0] i_load_val,
  output logic               o_expire
);

  logic [TIMER_W-1:0] r_cnt;

  always_ff @(posedge rclk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - TIMER_W'(1);
    end
  end

  assign o_expire = (r_cnt == TIMER_W'(1));

endmodule

// File: rtl/pll_ctrl.sv
// PLL supervisor: programs fbdiv, enables pll_core, waits for lock with bounded
// retries, and re-acquires on lock loss or a multiplier change. All outputs registered.
module pll_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES       = 4,
  parameter int LOCK_TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRIES         = 2,
  parameter int TIMER_W             = 11
) (
  input  logic       rclk,
  input  logic       rst,
  pll_ctrl_if.slave  bus
);

  localparam logic [TIMER_W-1:0] SETTLE_LD = TIMER_W'(SETTLE_CYCLES);
  localparam logic [TIMER_W-1:0] LOCK_LD   = TIMER_W'(LOCK_TIMEOUT_CYCLES);

  pll_ctrl_state_e    r_state;
  logic               r_pll_en;
  logic [FBDIV_W-1:0] r_pll_fbdiv;
  logic               r_ready;
  logic               r_busy;
  logic               r_err_timeout;
  logic               r_lock_lost;
  logic [RETRY_W-1:0] r_retry_cnt;

  pll_ctrl_state_e    w_nxt_state;
  logic [FBDIV_W-1:0] w_nxt_fbdiv;
  logic               w_nxt_lock_lost;
  logic [RETRY_W-1:0] w_nxt_retry_cnt;
  logic               w_tmr_load;
  logic [TIMER_W-1:0] w_tmr_load_val;
  logic               w_tmr_expire;
  logic [FBDIV_W-1:0] w_fbd_mapped;
  logic               w_fbd_change;
  logic               w_retry_left;

  function automatic logic [RETRY_W-1:0] retry_sat_inc(input logic [RETRY_W-1:0] cnt);
    return (cnt == RETRY_SAT) ? cnt : cnt + RETRY_W'(1);
  endfunction

  pll_ctrl_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .rclk       (rclk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_load_val),
    .o_expire   (w_tmr_expire)
  );

  assign w_fbd_mapped = fbdiv_map(bus.req_fbdiv);
  assign w_fbd_change = (w_fbd_mapped != r_pll_fbdiv);
  assign w_retry_left = (int'(r_retry_cnt) < MAX_RETRIES);

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_fbdiv     = r_pll_fbdiv;
    w_nxt_lock_lost = r_lock_lost;
    w_nxt_retry_cnt = r_retry_cnt;
    w_tmr_load      = 1'b0;
    w_tmr_load_val  = SETTLE_LD;

    if (!bus.req_en) begin
      w_nxt_state     = IDLE;
      w_nxt_lock_lost = 1'b0;
      w_nxt_retry_cnt = '0;
    end else if (w_fbd_change &&
                 (r_state == SETTLE || r_state == ACQUIRE || r_state == LOCKED)) begin
      // New multiplier: drop en in the same cycle fbdiv moves, then settle again.
      w_nxt_state     = SETTLE;
      w_nxt_fbdiv     = w_fbd_mapped;
      w_nxt_retry_cnt = '0;
      w_tmr_load      = 1'b1;
      w_tmr_load_val  = SETTLE_LD;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_nxt_state     = SETTLE;
          w_nxt_fbdiv     = w_fbd_mapped;
          w_nxt_lock_lost = 1'b0;
          w_nxt_retry_cnt = '0;
          w_tmr_load      = 1'b1;
          w_tmr_load_val  = SETTLE_LD;
        end
        SETTLE: begin
          if (w_tmr_expire) begin
            w_nxt_state    = ACQUIRE;
            w_tmr_load     = 1'b1;
            w_tmr_load_val = LOCK_LD;
          end
        end
        ACQUIRE: begin
          // Lock is checked first so a lock on the final timeout cycle still counts.
          if (bus.pll_lock) begin
            w_nxt_state = LOCKED;
          end else if (w_tmr_expire) begin
            if (w_retry_left) begin
              w_nxt_state     = SETTLE;
              w_nxt_retry_cnt = retry_sat_inc(r_retry_cnt);
              w_tmr_load      = 1'b1;
              w_tmr_load_val  = SETTLE_LD;
            end else begin
              w_nxt_state = ERROR;
            end
          end
        end
        LOCKED: begin
          if (!bus.pll_lock) begin
            w_nxt_state     = ACQUIRE;
            w_nxt_lock_lost = 1'b1;
            w_nxt_retry_cnt = '0;
            w_tmr_load      = 1'b1;
            w_tmr_load_val  = LOCK_LD;
          end
        end
        ERROR: begin
          w_nxt_state = ERROR;
        end
        default: begin
          w_nxt_state = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge rclk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_pll_en      <= 1'b0;
      r_pll_fbdiv   <= FBDIV_W'(1);
      r_ready       <= 1'b0;
      r_busy        <= 1'b0;
      r_err_timeout <= 1'b0;
      r_lock_lost   <= 1'b0;
      r_retry_cnt   <= '0;
    end else begin
      r_state       <= w_nxt_state;
      r_pll_en      <= (w_nxt_state == ACQUIRE) || (w_nxt_state == LOCKED);
      r_pll_fbdiv   <= w_nxt_fbdiv;
      r_ready       <= (w_nxt_state == LOCKED);
      r_busy        <= (w_nxt_state == SETTLE) || (w_nxt_state == ACQUIRE);
      r_err_timeout <= (w_nxt_state == ERROR);
      r_lock_lost   <= w_nxt_lock_lost;
      r_retry_cnt   <= w_nxt_retry_cnt;
    end
  end

  assign bus.pll_en      = r_pll_en;
  assign bus.pll_fbdiv   = r_pll_fbdiv;
  assign bus.ready       = r_ready;
  assign bus.busy        = r_busy;
  assign bus.err_timeout = r_err_timeout;
  assign bus.lock_lost   = r_lock_lost;
  assign bus.retry_cnt   = r_retry_cnt;

endmodule

// File: tb/tb_pll_ctrl.sv
// Directed bench for pll_ctrl: expectations are queued with the cycle they are due
// and compared when the bench reaches that cycle.
module tb_pll_ctrl;

  localparam int SETTLE = 4;
  localparam int TMO    = 16;
  localparam int MAXR   = 2;
  localparam int TW     = 11;

  localparam int S_EN    = 0;
  localparam int S_FBD   = 1;
  localparam int S_RDY   = 2;
  localparam int S_BUSY  = 3;
  localparam int S_ERR   = 4;
  localparam int S_LOST  = 5;
  localparam int S_RETRY = 6;

  typedef struct {
    string      tag;
    int         cyc;
    int         sig;
    logic [7:0] val;
  } exp_t;

  logic rclk = 1'b0;
  logic rst;

  pll_ctrl_if bus ();

  pll_ctrl #(
    .SETTLE_CYCLES       (SETTLE),
    .LOCK_TIMEOUT_CYCLES (TMO),
    .MAX_RETRIES         (MAXR),
    .TIMER_W             (TW)
  ) dut (
    .rclk (rclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 rclk = ~rclk;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   t0     = 0;

  function automatic logic [7:0] obs(input int sig);
    case (sig)
      S_EN:    return {7'd0, bus.pll_en};
      S_FBD:   return bus.pll_fbdiv;
      S_RDY:   return {7'd0, bus.ready};
      S_BUSY:  return {7'd0, bus.busy};
      S_ERR:   return {7'd0, bus.err_timeout};
      S_LOST:  return {7'd0, bus.lock_lost};
      S_RETRY: return {6'd0, bus.retry_cnt};
      default: return 8'hxx;
    endcase
  endfunction

  task automatic expect_v(input string tag, input int rel, input int sig, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.cyc = t0 + rel;
    e.sig = sig;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic expect_reset(input string tag, input int rel);
    expect_v({tag, "_en"},    rel, S_EN,    8'd0);
    expect_v({tag, "_fbd"},   rel, S_FBD,   8'd1);
    expect_v({tag, "_rdy"},   rel, S_RDY,   8'd0);
    expect_v({tag, "_busy"},  rel, S_BUSY,  8'd0);
    expect_v({tag, "_err"},   rel, S_ERR,   8'd0);
    expect_v({tag, "_lost"},  rel, S_LOST,  8'd0);
    expect_v({tag, "_retry"}, rel, S_RETRY, 8'd0);
  endtask

  task automatic check_due();
    exp_t       e;
    logic [7:0] o;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        e = sb[i];
        sb.delete(i);
        o = obs(e.sig);
        checks++;
        assert (o === e.val) else begin
          errors++;
          $error("FAIL %s cyc=%0d observed=%0h expected=%0h", e.tag, cyc, o, e.val);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge rclk);
    #1;
    cyc++;
    check_due();
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_en    = 1'b0;
    bus.req_fbdiv = 8'd0;
    bus.pll_lock  = 1'b0;

    // Reset state
    t0 = 0;
    expect_reset("rst0", 1);
    step();
    step();
    rst = 1'b0;
    step();

    // Nominal acquire: en at cycle 5, lock seen at 10, ready at 11
    t0 = cyc;
    bus.req_en    = 1'b1;
    bus.req_fbdiv = 8'd8;
    expect_v("nom_busy",    1,  S_BUSY,  8'd1);
    expect_v("nom_fbd",     1,  S_FBD,   8'd8);
    expect_v("nom_en_lo",   4,  S_EN,    8'd0);
    expect_v("nom_en_hi",   5,  S_EN,    8'd1);
    expect_v("nom_rdy_lo",  10, S_RDY,   8'd0);
    expect_v("nom_rdy",     11, S_RDY,   8'd1);
    expect_v("nom_busy_lo", 11, S_BUSY,  8'd0);
    expect_v("nom_retry",   11, S_RETRY, 8'd0);
    run_to(t0 + 10);
    bus.pll_lock = 1'b1;
    run_to(t0 + 13);

    // Lock loss for one cycle
    t0 = cyc;
    bus.pll_lock = 1'b0;
    expect_v("ll_rdy_lo", 1, S_RDY,  8'd0);
    expect_v("ll_lost",   1, S_LOST, 8'd1);
    expect_v("ll_en",     1, S_EN,   8'd1);
    expect_v("ll_busy",   1, S_BUSY, 8'd1);
    expect_v("ll_relock", 2, S_RDY,  8'd1);
    expect_v("ll_sticky", 2, S_LOST, 8'd1);
    step();
    bus.pll_lock = 1'b1;
    run_to(t0 + 3);

    // Multiplier change while locked
    t0 = cyc;
    bus.req_fbdiv = 8'd12;
    expect_v("fc_en_lo",   1, S_EN,   8'd0);
    expect_v("fc_fbd",     1, S_FBD,  8'd12);
    expect_v("fc_lost",    1, S_LOST, 8'd1);
    expect_v("fc_rdy_lo",  1, S_RDY,  8'd0);
    expect_v("fc_settle",  4, S_EN,   8'd0);
    expect_v("fc_en_hi",   5, S_EN,   8'd1);
    expect_v("fc_fbd_hold",5, S_FBD,  8'd12);
    expect_v("fc_rdy",     6, S_RDY,  8'd1);
    run_to(t0 + 7);

    // Zero multiplier maps to 1, then abort during ACQUIRE
    t0 = cyc;
    bus.req_fbdiv = 8'd0;
    bus.pll_lock  = 1'b0;
    expect_v("z_fbd",     1, S_FBD,  8'd1);
    expect_v("z_en_lo",   1, S_EN,   8'd0);
    expect_v("z_acq_en",  5, S_EN,   8'd1);
    expect_v("z_acq_busy",5, S_BUSY, 8'd1);
    expect_v("ab_en",     7, S_EN,   8'd0);
    expect_v("ab_rdy",    7, S_RDY,  8'd0);
    expect_v("ab_busy",   7, S_BUSY, 8'd0);
    expect_v("ab_err",    7, S_ERR,  8'd0);
    expect_v("ab_lost",   7, S_LOST, 8'd0);
    expect_v("ab_fbd",    7, S_FBD,  8'd1);
    run_to(t0 + 6);
    bus.req_en = 1'b0;
    run_to(t0 + 9);

    // Timeout with retries, then ERROR cleared by dropping req_en
    t0 = cyc;
    bus.req_en    = 1'b1;
    bus.req_fbdiv = 8'd8;
    bus.pll_lock  = 1'b0;
    expect_v("to_w1_en",   5,  S_EN,    8'd1);
    expect_v("to_w1_end",  20, S_EN,    8'd1);
    expect_v("to_r0",      20, S_RETRY, 8'd0);
    expect_v("to_gap1",    21, S_EN,    8'd0);
    expect_v("to_r1",      21, S_RETRY, 8'd1);
    expect_v("to_gap1_bz", 21, S_BUSY,  8'd1);
    expect_v("to_gap1_e",  24, S_EN,    8'd0);
    expect_v("to_w2_en",   25, S_EN,    8'd1);
    expect_v("to_w2_end",  40, S_EN,    8'd1);
    expect_v("to_r2",      41, S_RETRY, 8'd2);
    expect_v("to_gap2",    41, S_EN,    8'd0);
    expect_v("to_w3_en",   45, S_EN,    8'd1);
    expect_v("to_w3_end",  60, S_EN,    8'd1);
    expect_v("to_no_err",  60, S_ERR,   8'd0);
    expect_v("to_err",     61, S_ERR,   8'd1);
    expect_v("to_err_en",  61, S_EN,    8'd0);
    expect_v("to_err_bz",  61, S_BUSY,  8'd0);
    expect_v("to_err_rt",  61, S_RETRY, 8'd2);
    expect_v("to_err_hold",70, S_ERR,   8'd1);
    expect_v("to_clr_err", 71, S_ERR,   8'd0);
    expect_v("to_clr_en",  71, S_EN,    8'd0);
    expect_v("to_clr_bz",  71, S_BUSY,  8'd0);
    run_to(t0 + 70);
    bus.req_en = 1'b0;
    run_to(t0 + 72);

    // Lock arriving on the last cycle of the second window
    step();
    t0 = cyc;
    bus.req_en = 1'b1;
    expect_v("lt_r1",      21, S_RETRY, 8'd1);
    expect_v("lt_w2_en",   25, S_EN,    8'd1);
    expect_v("lt_rdy_lo",  40, S_RDY,   8'd0);
    expect_v("lt_rdy",     41, S_RDY,   8'd1);
    expect_v("lt_retry",   41, S_RETRY, 8'd1);
    expect_v("lt_busy",    41, S_BUSY,  8'd0);
    expect_v("lt_err",     41, S_ERR,   8'd0);
    run_to(t0 + 40);
    bus.pll_lock = 1'b1;
    run_to(t0 + 43);

    // Reset while LOCKED with lock still high
    rst = 1'b1;
    expect_reset("rst_lk", 44);
    run_to(t0 + 44);
    rst        = 1'b0;
    bus.req_en = 1'b0;
    step();

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
